jt10_adpcmb_fetch: RTL

- Memory-reader end of the ADPCM-B address stream: follows the channel's `{addr, nibble_sel}` pointer and fetches sample bytes from external ROM/SDRAM over a cs/ok handshake.
- Presents the addressed 4-bit nibble to the ADPCM-B decoder.
- Holds a two-entry byte buffer (current + prefetched next byte) so nibble delivery keeps up with the 55 kHz sample advance despite variable memory latency.

---
 rtl/jt10_adpcmb_fetch_pkg.sv | 17 +
 rtl/jt10_adpcmb_fetch_if.sv | 13 +
 rtl/jt10_adpcmb_fetch_bytebuf.sv | 69 ++++++
 rtl/jt10_adpcmb_fetch.sv | 137 +++++++++++++
 4 files changed

// File: rtl/jt10_adpcmb_fetch_pkg.sv
// Shared ADPCM-B fetch definitions: address width, nibble order, buffer target and FSM states.
package jt10_adpcmb_fetch_pkg;

    localparam int unsigned ADDR_W = 24;

    // High nibble plays first: nibble_sel==0 selects byte[7:4]
    localparam logic NIB_SEL_HI = 1'b0;

    typedef enum logic {CUR, NXT} target_e;

    typedef enum logic {IDLE, REQ} state_e;

    function automatic logic [3:0] pick_nibble(input logic [7:0] b, input logic sel);
        return (sel == NIB_SEL_HI) ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/jt10_adpcmb_fetch_if.sv
// Byte-wide memory read port with cs/ok handshake.
interface jt10_adpcmb_fetch_if;
    import jt10_adpcmb_fetch_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_cs;
    logic [7:0]        rom_data;
    logic              rom_ok;

    modport master (output rom_addr, rom_cs, input rom_data, rom_ok);
    modport slave  (input rom_addr, rom_cs, output rom_data, rom_ok);

endinterface

// File: rtl/jt10_adpcmb_fetch_bytebuf.sv
// Two-entry byte buffer (current + prefetched next) with tag compare, promote and invalidate.
module jt10_adpcmb_bytebuf
    import jt10_adpcmb_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_wr_cur,
    input  logic              i_wr_nxt,
    input  logic [7:0]        i_wr_byte,
    input  logic [ADDR_W-1:0] i_wr_tag,
    output logic              o_hit,
    output logic              o_miss,
    output logic              o_cur_v,
    output logic              o_nxt_v,
    output logic [ADDR_W-1:0] o_cur_tag,
    output logic [7:0]        o_cur_byte
);

    logic [7:0]        r_cur_byte, r_nxt_byte;
    logic [ADDR_W-1:0] r_cur_tag, r_nxt_tag;
    logic              r_cur_v, r_nxt_v;
    logic              w_hit_nxt;

    assign o_hit      = r_cur_v && (i_addr == r_cur_tag);
    assign w_hit_nxt  = !o_hit && r_nxt_v && (i_addr == r_nxt_tag);
    assign o_miss     = !o_hit && !w_hit_nxt;
    assign o_cur_v    = r_cur_v;
    assign o_nxt_v    = r_nxt_v;
    assign o_cur_tag  = r_cur_tag;
    assign o_cur_byte = r_cur_byte;

    // Lookup every clk; a memory fill is applied last so it survives a same-cycle invalidate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_byte <= '0;
            r_nxt_byte <= '0;
            r_cur_tag  <= '0;
            r_nxt_tag  <= '0;
            r_cur_v    <= 1'b0;
            r_nxt_v    <= 1'b0;
        end else if (i_flush) begin
            r_cur_v <= 1'b0;
            r_nxt_v <= 1'b0;
        end else begin
            if (w_hit_nxt) begin
                r_cur_byte <= r_nxt_byte;
                r_cur_tag  <= r_nxt_tag;
                r_cur_v    <= 1'b1;
                r_nxt_v    <= 1'b0;
            end else if (o_miss) begin
                r_cur_v <= 1'b0;
                r_nxt_v <= 1'b0;
            end
            if (i_wr_cur) begin
                r_cur_byte <= i_wr_byte;
                r_cur_tag  <= i_wr_tag;
                r_cur_v    <= 1'b1;
            end
            if (i_wr_nxt) begin
                r_nxt_byte <= i_wr_byte;
                r_nxt_tag  <= i_wr_tag;
                r_nxt_v    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt10_adpcmb_fetch.sv
// ADPCM-B sample fetcher: follows {addr, nibble_sel}, fetches bytes over cs/ok and presents nibbles.
module jt10_adpcmb_fetch
    import jt10_adpcmb_fetch_pkg::*;
#(
    parameter int unsigned OK_MASK = 1
)(
    input  logic                       rst_n,
    input  logic                       clk,
    input  logic                       cen,
    input  logic                       chon,
    input  logic                       adv,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       nibble_sel,
    jt10_adpcmb_fetch_if.master        rom,
    output logic [3:0]                 data,
    output logic                       data_ok,
    input  logic                       clr_under,
    output logic                       underrun
);

    state_e            r_state, w_state_nxt;
    target_e           r_target, w_target_nxt;
    logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_nxt;
    logic [1:0]        r_mask, w_mask_nxt;
    logic [3:0]        r_data;
    logic              r_data_ok;
    logic              r_under;

    logic              w_hit, w_miss, w_cur_v, w_nxt_v;
    logic [ADDR_W-1:0] w_cur_tag, w_cur_succ;
    logic [7:0]        w_cur_byte;
    logic              w_wr_cur, w_wr_nxt;

    assign w_cur_succ   = w_cur_tag + ADDR_W'(1);
    assign rom.rom_addr = r_rom_addr;
    assign rom.rom_cs   = (r_state == REQ);
    assign data         = r_data;
    assign data_ok      = r_data_ok;
    assign underrun     = r_under;

    jt10_adpcmb_bytebuf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (!chon),
        .i_addr     (addr),
        .i_wr_cur   (w_wr_cur),
        .i_wr_nxt   (w_wr_nxt),
        .i_wr_byte  (rom.rom_data),
        .i_wr_tag   (r_rom_addr),
        .o_hit      (w_hit),
        .o_miss     (w_miss),
        .o_cur_v    (w_cur_v),
        .o_nxt_v    (w_nxt_v),
        .o_cur_tag  (w_cur_tag),
        .o_cur_byte (w_cur_byte)
    );

    // Fetch FSM state, target, request address and ok-mask counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_target   <= CUR;
            r_rom_addr <= '0;
            r_mask     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_mask     <= w_mask_nxt;
        end
    end

    // Request decision in IDLE; in REQ, accept ok after the mask and keep the byte only if still wanted
    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_rom_addr_nxt = r_rom_addr;
        w_mask_nxt     = r_mask;
        w_wr_cur       = 1'b0;
        w_wr_nxt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (chon && w_miss) begin
                    w_target_nxt   = CUR;
                    w_rom_addr_nxt = addr;
                    w_mask_nxt     = 2'(OK_MASK);
                    w_state_nxt    = REQ;
                end else if (chon && w_cur_v && !w_nxt_v) begin
                    w_target_nxt   = NXT;
                    w_rom_addr_nxt = w_cur_succ;
                    w_mask_nxt     = 2'(OK_MASK);
                    w_state_nxt    = REQ;
                end
            end
            REQ: begin
                if (!chon) begin
                    w_state_nxt = IDLE;
                end else if (r_mask != 2'd0) begin
                    w_mask_nxt = r_mask - 2'd1;
                end else if (rom.rom_ok) begin
                    w_state_nxt = IDLE;
                    if (r_target == CUR) begin
                        w_wr_cur = (r_rom_addr == addr);
                    end else begin
                        w_wr_nxt = w_cur_v && (r_rom_addr == w_cur_succ);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered nibble output; data holds its last value while there is no hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_ok <= 1'b0;
            r_data    <= '0;
        end else begin
            r_data_ok <= chon && w_hit;
            if (chon && w_hit) begin
                r_data <= pick_nibble(w_cur_byte, nibble_sel);
            end
        end
    end

    // Sticky underrun flag; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_under <= 1'b0;
        end else if (cen && adv && chon && !r_data_ok) begin
            r_under <= 1'b1;
        end else if (clr_under) begin
            r_under <= 1'b0;
        end
    end

endmodule
